// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU op codes, CP0 register numbers, exception codes and FSM states
package mips_pkg;

  localparam logic [4:0] A_ADD  = 5'h01;
  localparam logic [4:0] A_SUB  = 5'h02;
  localparam logic [4:0] A_ADDU = 5'h07;
  localparam logic [4:0] A_SUBU = 5'h08;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_STAT   = 5'd22;

  localparam logic [4:0] EXC_OV = 5'h0C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } exc_state_e;

  // Restart address: a faulting delay-slot instruction resumes at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// rtl/cp0_regs.sv - CP0 EPC/Cause/Status/statistics registers with combinational read mux
module cp0_regs
  import mips_pkg::*;
#(
  parameter logic [4:0] EXC_CODE = EXC_OV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic        trap_bd_i,
  input  logic        exl_clr_i,
  input  logic        carry_set_i,
  input  logic        lost_inc_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  input  logic [4:0]  mfc0_addr_i,
  output logic [31:0] mfc0_data_o,
  output logic [31:0] epc_o,
  output logic        exl_o,
  output logic        carry_o
);

  logic [31:0] epc_q, epc_d;
  logic        cause_bd_q, cause_bd_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  ov_lost_q, ov_lost_d;
  logic        carry_q, carry_d;

  logic unused_data_bits;
  assign unused_data_bits = ^mtc0_data_i[30:7];

  // Next-state: software writes first, hardware trap capture overrides the same register.
  always_comb begin
    epc_d       = epc_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    status_d    = status_q;
    ov_lost_d   = ov_lost_q;
    carry_d     = carry_q;

    if (mtc0_we_i) begin
      case (mtc0_addr_i)
        CP0_STATUS: status_d = mtc0_data_i[1:0];
        CP0_CAUSE: begin
          cause_bd_d  = mtc0_data_i[31];
          cause_exc_d = mtc0_data_i[6:2];
        end
        CP0_EPC:  epc_d = mtc0_data_i;
        CP0_STAT: if (!mtc0_data_i[0]) carry_d = 1'b0;
        default: ;
      endcase
    end

    if (carry_set_i) carry_d = 1'b1;

    if (lost_inc_i && (ov_lost_q != 8'hFF)) ov_lost_d = ov_lost_q + 8'd1;

    if (trap_i) begin
      epc_d       = epc_of(trap_pc_i, trap_bd_i);
      cause_bd_d  = trap_bd_i;
      cause_exc_d = EXC_CODE;
      status_d    = {1'b1, status_q[0]};
    end

    if (exl_clr_i) status_d[1] = 1'b0;
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q       <= '0;
      cause_bd_q  <= 1'b0;
      cause_exc_q <= '0;
      status_q    <= '0;
      ov_lost_q   <= '0;
      carry_q     <= 1'b0;
    end else begin
      epc_q       <= epc_d;
      cause_bd_q  <= cause_bd_d;
      cause_exc_q <= cause_exc_d;
      status_q    <= status_d;
      ov_lost_q   <= ov_lost_d;
      carry_q     <= carry_d;
    end
  end

  // Combinational CP0 read port.
  always_comb begin
    mfc0_data_o = '0;
    case (mfc0_addr_i)
      CP0_EPC:    mfc0_data_o = epc_q;
      CP0_CAUSE:  mfc0_data_o = {cause_bd_q, 24'b0, cause_exc_q, 2'b0};
      CP0_STATUS: mfc0_data_o = {30'b0, status_q};
      CP0_STAT:   mfc0_data_o = {16'b0, ov_lost_q, 7'b0, carry_q};
      default:    mfc0_data_o = '0;
    endcase
  end

  assign epc_o   = epc_q;
  assign exl_o   = status_q[1];
  assign carry_o = carry_q;

endmodule

// File: rtl/ovf_exception_ctrl.sv
// rtl/ovf_exception_ctrl.sv - arithmetic overflow trap sequencer with flush/redirect/return FSM
module ovf_exception_ctrl #(
  parameter logic [31:0] HANDLER_VEC  = 32'h8000_0180,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [4:0]  EXC_OV       = mips_pkg::EXC_OV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_op,
  input  logic        ex_overflow,
  input  logic [31:0] ex_pc,
  input  logic        ex_bd,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        carry_sticky
);
  import mips_pkg::*;

  exc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;

  logic        signed_ov;
  logic        trap;
  logic        exl;
  logic [31:0] epc;

  // Classify the EX-stage overflow: signed ops trap when possible, otherwise count as lost.
  always_comb begin
    signed_ov = ex_valid && ex_overflow && ((ex_op == A_ADD) || (ex_op == A_SUB));
    trap      = signed_ov && (state_q == ST_IDLE) && !exl;
  end

  cp0_regs #(
    .EXC_CODE(EXC_OV)
  ) u_cp0 (
    .clk         (clk),
    .rst         (rst),
    .trap_i      (trap),
    .trap_pc_i   (ex_pc),
    .trap_bd_i   (ex_bd),
    .exl_clr_i   (state_q == ST_RETURN),
    .carry_set_i (ex_valid && ex_overflow && ((ex_op == A_ADDU) || (ex_op == A_SUBU))),
    .lost_inc_i  (signed_ov && !trap),
    .mtc0_we_i   (mtc0_we),
    .mtc0_addr_i (mtc0_addr),
    .mtc0_data_i (mtc0_data),
    .mfc0_addr_i (mfc0_addr),
    .mfc0_data_o (mfc0_data),
    .epc_o       (epc),
    .exl_o       (exl),
    .carry_o     (carry_sticky)
  );

  // Next state and the registered flush/redirect values for the following cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    rv_d    = 1'b0;
    rpc_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (trap) begin
          state_d = ST_FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
          flush_d = 1'b1;
          rv_d    = 1'b1;
          rpc_d   = HANDLER_VEC;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_HANDLER;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      ST_HANDLER: begin
        if (eret) begin
          state_d = ST_RETURN;
          flush_d = 1'b1;
          rv_d    = 1'b1;
          rpc_d   = epc;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

endmodule
